decode_ctrl_queue: RTL and testbench

Parametrised buffer of decoded control words between decode and execute. It replaces the flat control bus with a DEPTH-entry queue that uses valid/ready handshakes on both sides. Words are packed as ctrl_word_t: all control_bus fields, 83 bits. The queue adds three behaviours: a synch barrier at the head, a halt latch on the input side, and a single-cycle pipeline flush.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_ctrl_queue_if.sv | 21 ++
 rtl/ctrl_fifo_core.sv | 62 ++++++
 rtl/decode_ctrl_queue.sv | 90 +++++++++
 tb/tb_decode_ctrl_queue.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode-to-execute control word queue.
package decode_pkg;

    // Flags sit at the MSB end so small test words never trip them.
    typedef struct packed {
        logic       halt;
        logic       synch_req;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [3:0] alu_op;
        logic [3:0] valu_op;
        logic [2:0] op_type;
        logic [2:0] w_type;
        logic [2:0] r_type;
        logic [15:0] mask;
        logic [3:0] mm_opcode;
        logic [7:0] mm_idx;
        logic       vreg_we;
        logic       sreg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       mm_en;
        logic       branch;
    } ctrl_word_t;

    localparam int unsigned CTRL_W   = $bits(ctrl_word_t);
    localparam int unsigned HALT_BIT = CTRL_W - 1;
    localparam int unsigned SYNC_BIT = CTRL_W - 2;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SYNC_WAIT = 2'd1,
        SYNC_GO   = 2'd2
    } head_state_e;

endpackage

// File: rtl/decode_ctrl_queue_if.sv
// Valid/ready handshake bundle for both sides of the control word queue.
interface decode_ctrl_queue_if #(
    parameter int unsigned CTRL_W = decode_pkg::CTRL_W
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_ctrl, out_ready,
        output in_ready, out_valid, out_ctrl
    );

    modport master (
        output in_valid, in_ctrl, out_ready,
        input  in_ready, out_valid, out_ctrl
    );
endinterface

// File: rtl/ctrl_fifo_core.sv
// Generic synchronous FIFO; head reads zero when empty, clear drops all entries.
module ctrl_fifo_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/decode_ctrl_queue.sv
// Control word queue between decode and execute with synch barrier, halt latch and flush.
module decode_ctrl_queue
    import decode_pkg::*;
#(
    parameter int unsigned CTRL_W   = decode_pkg::CTRL_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned SYNC_BIT = decode_pkg::SYNC_BIT,
    parameter int unsigned HALT_BIT = decode_pkg::HALT_BIT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    decode_ctrl_queue_if.slave         bus,
    input  logic                       sync_ack,
    output logic                       sync_pend,
    output logic                       halt_latched,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_WAIT = SYNC_WAIT;
    localparam logic [1:0] ST_GO   = SYNC_GO;

    logic [1:0]        state_q, state_d;
    logic              halt_q, halt_d;
    logic [CTRL_W-1:0] head;
    logic              head_sync, enq, deq;
    logic              in_ready, out_valid, sync_pend_w;

    ctrl_fifo_core #(.WIDTH(CTRL_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (enq),
        .pop   (deq),
        .wdata (bus.in_ctrl),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign head_sync = !empty && head[SYNC_BIT];
    assign in_ready  = !full && !halt_q && !flush;
    assign enq       = bus.in_valid && in_ready;
    assign deq       = out_valid && bus.out_ready;

    // Head FSM: a synch word is held until sync_ack releases it.
    always_comb begin
        state_d     = state_q;
        out_valid   = 1'b0;
        sync_pend_w = head_sync && (state_q != ST_GO);
        case (state_q)
            ST_RUN: begin
                out_valid = !empty && !flush && !head_sync;
                if (head_sync) state_d = sync_ack ? ST_GO : ST_WAIT;
            end
            ST_WAIT: if (sync_ack) state_d = ST_GO;
            ST_GO: begin
                out_valid = !empty && !flush;
                if (deq) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_RUN;
    end

    always_comb begin
        halt_d = halt_q;
        if (flush)                         halt_d = 1'b0;
        else if (enq && bus.in_ctrl[HALT_BIT]) halt_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = head;
    assign sync_pend     = sync_pend_w;
    assign halt_latched  = halt_q;
endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Directed bench for decode_ctrl_queue with a queue-based reference model.
module tb_decode_ctrl_queue;
    import decode_pkg::*;

    localparam int unsigned W     = decode_pkg::CTRL_W;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SB    = decode_pkg::SYNC_BIT;
    localparam int unsigned HB    = decode_pkg::HALT_BIT;

    logic clk = 1'b0;
    logic rst_n, flush, sync_ack;
    logic sync_pend, halt_latched, empty, full;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    decode_ctrl_queue_if bus ();

    decode_ctrl_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .sync_ack     (sync_ack),
        .sync_pend    (sync_pend),
        .halt_latched (halt_latched),
        .count        (count),
        .empty        (empty),
        .full         (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents, halt flag, and whether the synch head was released.
    logic [W-1:0] mq[$];
    bit m_halt = 1'b0;
    bit m_rel  = 1'b0;

    always @(posedge clk) begin
        bit hs, ov, ir;
        if (!rst_n) begin
            mq.delete(); m_halt = 1'b0; m_rel = 1'b0;
        end else if (flush) begin
            mq.delete(); m_halt = 1'b0; m_rel = 1'b0;
        end else begin
            hs = (mq.size() != 0) && mq[0][SB];
            ov = (mq.size() != 0) && (!hs || m_rel);
            ir = (mq.size() < DEPTH) && !m_halt;
            if (ov && bus.out_ready) begin
                void'(mq.pop_front());
                m_rel = 1'b0;
            end else if (hs && sync_ack) begin
                m_rel = 1'b1;
            end
            if (bus.in_valid && ir) begin
                mq.push_back(bus.in_ctrl);
                if (bus.in_ctrl[HB]) m_halt = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        bit hs, e_ov, e_ir;
        logic [W-1:0] e_ctrl;
        hs     = (mq.size() != 0) && mq[0][SB];
        e_ov   = (mq.size() != 0) && !flush && (!hs || m_rel);
        e_ir   = (mq.size() < DEPTH) && !m_halt && !flush;
        e_ctrl = (mq.size() != 0) ? mq[0] : '0;
        chk("out_valid", 128'(bus.out_valid), 128'(e_ov));
        chk("in_ready", 128'(bus.in_ready), 128'(e_ir));
        chk("out_ctrl", 128'(bus.out_ctrl), 128'(e_ctrl));
        chk("sync_pend", 128'(sync_pend), 128'(hs && !m_rel));
        chk("halt_latched", 128'(halt_latched), 128'(m_halt));
        chk("count", 128'(count), 128'(mq.size()));
        chk("empty", 128'(empty), 128'(mq.size() == 0));
        chk("full", 128'(full), 128'(mq.size() == DEPTH));
    end

    task automatic drive(input logic iv, input logic [W-1:0] ic, input logic ordy,
                         input logic sa, input logic fl);
        bus.in_valid  = iv;
        bus.in_ctrl   = ic;
        bus.out_ready = ordy;
        sync_ack      = sa;
        flush         = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] s_w, h_w, s2_w, h2_w;

    initial begin
        s_w  = '0; s_w[SB]  = 1'b1; s_w[7:0]  = 8'h05;
        h_w  = '0; h_w[HB]  = 1'b1; h_w[7:0]  = 8'h22;
        s2_w = '0; s2_w[SB] = 1'b1; s2_w[7:0] = 8'h32;
        h2_w = '0; h2_w[HB] = 1'b1; h2_w[7:0] = 8'h33;

        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));

        // Fill and drain
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, W'(k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("fill_count", 128'(count), 128'(4));
        chk("fill_full", 128'(full), 128'(1));
        chk("fill_in_ready", 128'(bus.in_ready), 128'(0));
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            chk("drain_ctrl", 128'(bus.out_ctrl), 128'(k));
            chk("drain_valid", 128'(bus.out_valid), 128'(1));
            tick();
        end
        chk("drain_empty", 128'(empty), 128'(1));
        chk("drain_ctrl_zero", 128'(bus.out_ctrl), 128'(0));

        // Simultaneous traffic at count 2
        drive(1'b1, W'(8'h10), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, W'(8'h11), 1'b0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, W'(8'h12 + i), 1'b1, 1'b0, 1'b0);
            chk("thru_head", 128'(bus.out_ctrl), 128'(8'h10 + i));
            chk("thru_count", 128'(count), 128'(2));
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("thru_tail0", 128'(bus.out_ctrl), 128'(8'h1A));
        tick();
        chk("thru_tail1", 128'(bus.out_ctrl), 128'(8'h1B));
        tick();
        chk("thru_empty", 128'(empty), 128'(1));

        // Synch barrier; early ack while A at head is dropped
        drive(1'b1, W'(8'h0A), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, s_w, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b1, W'(8'h0B), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("sync_a_head", 128'(bus.out_ctrl), 128'(8'h0A));
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("sync_blocked_pend", 128'(sync_pend), 128'(1));
            chk("sync_blocked_valid", 128'(bus.out_valid), 128'(0));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sync_go_valid", 128'(bus.out_valid), 128'(1));
        chk("sync_go_ctrl", 128'(bus.out_ctrl), 128'(s_w));
        chk("sync_go_pend", 128'(sync_pend), 128'(0));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0); tick();
        chk("sync_b_ctrl", 128'(bus.out_ctrl), 128'(8'h0B));
        chk("sync_b_valid", 128'(bus.out_valid), 128'(1));
        tick();
        chk("sync_empty", 128'(empty), 128'(1));

        // Halt latch
        drive(1'b1, W'(8'h21), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, h_w, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, W'(8'h23), 1'b0, 1'b0, 1'b0);
        chk("halt_latched", 128'(halt_latched), 128'(1));
        chk("halt_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
        chk("halt_refused", 128'(count), 128'(2));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("halt_drain0", 128'(bus.out_ctrl), 128'(8'h21));
        tick();
        chk("halt_drain1", 128'(bus.out_ctrl), 128'(h_w));
        tick();
        chk("halt_drained", 128'(empty), 128'(1));
        chk("halt_sticky", 128'(halt_latched), 128'(1));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();

        // Flush with synch wait and halt pending
        drive(1'b1, s2_w, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, W'(8'h31), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, h2_w, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 128'(count), 128'(3));
        chk("pre_flush_pend", 128'(sync_pend), 128'(1));
        chk("pre_flush_halt", 128'(halt_latched), 128'(1));
        drive(1'b1, W'(8'h44), 1'b1, 1'b0, 1'b1);
        chk("flush_in_ready", 128'(bus.in_ready), 128'(0));
        chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("post_flush_count", 128'(count), 128'(0));
        chk("post_flush_pend", 128'(sync_pend), 128'(0));
        chk("post_flush_halt", 128'(halt_latched), 128'(0));
        chk("post_flush_in_ready", 128'(bus.in_ready), 128'(1));
        chk("post_flush_ctrl", 128'(bus.out_ctrl), 128'(0));

        // Reset while full and in synch wait
        drive(1'b1, s_w, 1'b0, 1'b0, 1'b0); tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, W'(8'h60 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_full", 128'(full), 128'(1));
        chk("pre_rst_pend", 128'(sync_pend), 128'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_out_ctrl", 128'(bus.out_ctrl), 128'(0));
        chk("mid_rst_pend", 128'(sync_pend), 128'(0));
        chk("mid_rst_count", 128'(count), 128'(0));
        chk("mid_rst_empty", 128'(empty), 128'(1));
        chk("mid_rst_full", 128'(full), 128'(0));
        chk("mid_rst_halt", 128'(halt_latched), 128'(0));
        drive(1'b1, W'(8'h55), 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_valid", 128'(bus.out_valid), 128'(1));
        chk("post_rst_ctrl", 128'(bus.out_ctrl), 128'(8'h55));
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
